// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM state type and operand width for the adder arbiter
package adder_arb_pkg;
  localparam int OP_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first requester at or after ptr
// ports: req (request vector), ptr (search start), grant (one-hot), idx (encoded), any (some request)
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  // scanning offsets downwards lets the nearest requester overwrite farther ones
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
  end
  assign any = |req;
  assign grant = any ? N'(1) << idx : '0;
endmodule

// File: rtl/adder_arb_ctrl.sv
// adder_arb_ctrl: round-robin sharing of one 1-cycle adder with start/done handshake and timeout
// ports: clk, reset (async active-low); req_valid/req_a/req_b/req_ready per requester;
//        add_start/add_a/add_b/add_done/add_result to the adder;
//        resp_valid/resp_ready/resp_id/resp_result/resp_err response; busy (not IDLE)
module adder_arb_ctrl import adder_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    add_start,
  output logic [OP_W-1:0]         add_a,
  output logic [OP_W-1:0]         add_b,
  input  logic                    add_done,
  input  logic [OP_W-1:0]         add_result,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [OP_W-1:0]         resp_result,
  output logic                    resp_err,
  output logic                    busy
);
  localparam int TW = $clog2(TIMEOUT);
  state_t state, state_d;
  logic [ID_W-1:0] rr_ptr, g_idx;
  logic [NUM_REQ-1:0] grant;
  logic any;
  logic [TW-1:0] timer;
  logic [OP_W-1:0] op_a, op_b;
  logic expired;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(g_idx),
    .any(any)
  );
  assign expired = timer == TW'(TIMEOUT - 1);
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = any ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = (add_done || expired) ? RESP : WAIT;
      default: state_d = resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      timer <= '0;
      op_a <= '0;
      op_b <= '0;
      resp_id <= '0;
      resp_result <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_d;
      timer <= (state == WAIT) ? timer + 1'b1 : '0;
      if (state == IDLE && any) begin
        op_a <= req_a[OP_W*g_idx +: OP_W];
        op_b <= req_b[OP_W*g_idx +: OP_W];
        resp_id <= g_idx;
        rr_ptr <= ID_W'((int'(g_idx) + 1) % NUM_REQ);
      end
      if (state == WAIT && (add_done || expired)) begin
        resp_result <= add_done ? add_result : '0;
        resp_err <= !add_done;
      end
    end
  end
  // gated by reset so no grant is visible while reset is held
  assign req_ready = (reset && state == IDLE) ? grant : '0;
  assign add_start = state == ISSUE;
  assign add_a = op_a;
  assign add_b = op_b;
  assign resp_valid = state == RESP;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_adder_arb_ctrl.sv
// tb_adder_arb_ctrl: directed checks of arbitration, adder handshake, backpressure, timeout and reset
module tb_adder_arb_ctrl;
  logic clk = 0, reset = 1;
  logic [3:0] req_valid = '0, req_ready;
  logic [15:0] req_a = '0, req_b = '0;
  logic add_start, add_done = 0, resp_valid, resp_ready = 1, resp_err, busy, stuck = 0;
  logic [3:0] add_a, add_b, add_result = '0, resp_result;
  logic [1:0] resp_id;
  int total = 0, pass = 0;
  adder_arb_ctrl #(.NUM_REQ(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_result(add_result), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    add_done <= reset && add_start && !stuck;
    add_result <= add_a + add_b;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".req_ready"}, req_ready, 0);
    chk({tag, ".add_start"}, add_start, 0);
    chk({tag, ".add_a"}, add_a, 0);
    chk({tag, ".add_b"}, add_b, 0);
    chk({tag, ".resp_valid"}, resp_valid, 0);
    chk({tag, ".resp_id"}, resp_id, 0);
    chk({tag, ".resp_result"}, resp_result, 0);
    chk({tag, ".resp_err"}, resp_err, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask
  logic [3:0] rr_hot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_sum [5] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd3};
  initial begin
    #1 reset = 0;
    req_valid = 4'b1111;
    step(2);
    #1 chk_zero("rst");
    req_valid = 4'b0100;
    req_a[11:8] = 4'h3;
    req_b[11:8] = 4'h4;
    reset = 1;
    #1 chk("single.ready", req_ready, 4'b0100);
    step;
    req_valid = 0;
    #1 chk("single.start", add_start, 1);
    chk("single.a", add_a, 3);
    chk("single.b", add_b, 4);
    chk("single.busy", busy, 1);
    step;
    #1 chk("single.start_off", add_start, 0);
    chk("single.wait_valid", resp_valid, 0);
    step;
    #1 chk("single.valid", resp_valid, 1);
    chk("single.id", resp_id, 2);
    chk("single.sum", resp_result, 7);
    chk("single.err", resp_err, 0);
    step;
    #1 chk("single.done", resp_valid, 0);
    chk("single.idle", busy, 0);
    req_valid = 4'b0001;
    req_a[3:0] = 4'hF;
    req_b[3:0] = 4'h1;
    #1 chk("wrap.ready", req_ready, 4'b0001);
    step;
    req_valid = 0;
    step(2);
    #1 chk("wrap.valid", resp_valid, 1);
    chk("wrap.id", resp_id, 0);
    chk("wrap.sum", resp_result, 0);
    chk("wrap.err", resp_err, 0);
    step;
    reset = 0;
    req_a = {4'h4, 4'h3, 4'h2, 4'h1};
    req_b = {4'h8, 4'h6, 4'h4, 4'h2};
    req_valid = 4'b1111;
    step;
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rr%0d.ready", k), req_ready, rr_hot[k]);
      step(2);
      #1 chk($sformatf("rr%0d.early", k), resp_valid, 0);
      step;
      #1 chk($sformatf("rr%0d.valid", k), resp_valid, 1);
      chk($sformatf("rr%0d.id", k), resp_id, k % 4);
      chk($sformatf("rr%0d.sum", k), resp_result, rr_sum[k]);
      step;
    end
    req_valid = 4'b0010;
    resp_ready = 0;
    #1 chk("bp.ready", req_ready, 4'b0010);
    step(3);
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("bp%0d.valid", k), resp_valid, 1);
      chk($sformatf("bp%0d.id", k), resp_id, 1);
      chk($sformatf("bp%0d.sum", k), resp_result, 6);
      chk($sformatf("bp%0d.noready", k), req_ready, 0);
      step;
    end
    resp_ready = 1;
    #1 chk("bp.hold", resp_valid, 1);
    step;
    #1 chk("bp.released", resp_valid, 0);
    chk("bp.reaccept", req_ready, 4'b0010);
    req_valid = 4'b1000;
    req_a[15:12] = 4'h5;
    req_b[15:12] = 4'h5;
    stuck = 1;
    #1 chk("to.ready", req_ready, 4'b1000);
    step;
    req_valid = 0;
    #1 chk("to.start", add_start, 1);
    for (int k = 0; k < 4; k++) begin
      step;
      #1 chk($sformatf("to.wait%0d", k), resp_valid, 0);
    end
    step;
    #1 chk("to.valid", resp_valid, 1);
    chk("to.id", resp_id, 3);
    chk("to.err", resp_err, 1);
    chk("to.sum", resp_result, 0);
    step;
    req_valid = 4'b0100;
    #1 chk("rw.ready", req_ready, 4'b0100);
    step;
    req_valid = 0;
    step;
    req_valid = 4'b1010;
    reset = 0;
    #1 chk_zero("rw");
    step(2);
    req_valid = 0;
    stuck = 0;
    reset = 1;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("rw.noresp%0d", k), resp_valid, 0);
      chk($sformatf("rw.nobusy%0d", k), busy, 0);
      step;
    end
    req_valid = 4'b1111;
    #1 chk("rw.first", req_ready, 4'b0001);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/adder_arb_ctrl.md
# adder_arb_ctrl

Round-robin controller that shares one registered 4-bit adder among NUM_REQ requesters. It accepts one operand pair at a time, sequences the adder's start/done handshake and returns the 4-bit sum tagged with the requester ID. A watchdog flags an error response if the adder never raises done. It sits between client blocks and a single adder instance that has 1-cycle start-to-done latency.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 4, max cycles in WAIT before an error response (≥2)
- ID_W, $clog2(NUM_REQ), width of requester ID (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ×4  per-requester operand A (packed, requester i at [4i+3:4i])
- req_b  in  NUM_REQ×4  per-requester operand B, same packing
- req_ready  out  NUM_REQ  one-hot accept; handshake completes when valid&ready high at an edge
- add_start  out  1  start pulse to adder
- add_a  out  4  operand A to adder
- add_b  out  4  operand B to adder
- add_done  in  1  adder done
- add_result  in  4  adder sum
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  ID_W  requester index of response
- resp_result  out  4  sum (A+B mod 16); 0 when resp_err
- resp_err  out  1  timeout error flag
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant = first asserted requester at or after rr_ptr (wrapping). req_ready[grant]=1 combinationally, all others 0. On that edge: latch req_a/req_b of grant into op regs, latch ID, rr_ptr <= (grant+1) mod NUM_REQ, go ISSUE. No valid: stay, ready all 0.
- ISSUE: add_start=1, add_a/add_b driven from op regs; go WAIT, clear timer.
- WAIT: add_start=0; add_a/add_b hold op regs. If add_done: capture add_result, resp_err=0, go RESP. Else timer++; at timer==TIMEOUT-1 without done: resp_result=0, resp_err=1, go RESP.
- RESP: resp_valid=1, resp_id/resp_result/resp_err stable until resp_valid&resp_ready at an edge; then go IDLE, resp_valid=0.
- req_ready is 0 in all states except IDLE; requests never accepted while busy.
- add_done seen outside WAIT is ignored.
- Sum is 4-bit wrap: 4'hF + 4'h1 = 4'h0; no carry out.

## Timing
- Reset (async assert, sync release): state IDLE, rr_ptr 0, timer 0; all outputs 0 (req_ready, add_start, add_a, add_b, resp_valid, resp_id, resp_result, resp_err, busy).
- Reset mid-operation: in-flight transaction discarded, no response produced.
- Accept at cycle 0 edge → add_start high cycle 1 → add_done expected cycle 2 → resp_valid high cycle 3.
- With resp_ready held high: one transaction per 4 cycles; next accept in cycle 4.
- Error path: resp_valid rises TIMEOUT+1 cycles after ISSUE cycle.
- Simultaneous requests: exactly one granted per IDLE visit, round-robin fair; a continuously requesting client waits at most NUM_REQ-1 grants.
- busy = (state != IDLE), registered.

## Structure
- Package adder_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), operand width constant OP_W=4.
- Sub-module rr_arbiter: combinational grant from req vector and rr_ptr, outputs one-hot grant and encoded index; pointer register kept in top.
- Top: FSM, op/ID regs, timer, response regs.

## Test plan
- Single request: req 2 valid, A=3, B=4 → req_ready[2] cycle 0, add_start cycle 1 with 3/4, resp_valid cycle 3, resp_id=2, resp_result=7, resp_err=0.
- Wrap: A=F, B=1 → resp_result=0, resp_err=0.
- All four valid continuously, resp_ready=1, from reset → grant order 0,1,2,3,0, each response 4 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles → resp fields stable, req_ready stays 0, accept only after handshake.
- Adder stuck (add_done tied 0), TIMEOUT=4 → resp_valid with resp_err=1, resp_result=0, 5 cycles after ISSUE.
- Reset asserted during WAIT → all outputs 0 immediately, no response after release, next grant from requester 0.
